tile_result_writer: RTL

Write-back stage directly downstream of the matrix multiplier core. Captures the four 32-bit results of each 2×2 output tile as their staggered ready strobes fire. Computes each element's byte address from a tile base address and a row stride, then buffers {address, data} pairs in a small FIFO. Drains the FIFO to memory through a single-outstanding request/grant write port.

---
 rtl/tensor_pkg.sv | 30 +++
 rtl/result_fifo.sv | 47 ++++
 rtl/tile_result_writer.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/tensor_pkg.sv
// Shared types and constants for the tile result write-back path.
package tensor_pkg;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wb_entry_t;

    localparam logic [31:0] ELEM_BYTES = 32'd4;
    localparam logic [3:0]  WB_BE      = 4'hF;

    typedef enum logic [1:0] {
        WB_IDLE = 2'd0,
        WB_REQ  = 2'd1,
        WB_WAIT = 2'd2
    } wb_state_e;

    // Byte address of element (row, col) of a 2x2 tile, mod 2^32.
    function automatic logic [31:0] elem_addr(input logic [31:0] base,
                                              input logic [31:0] stride,
                                              input logic        row,
                                              input logic        col);
        logic [31:0] a;
        a = base;
        if (row) a = a + stride;
        if (col) a = a + ELEM_BYTES;
        return a;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous FIFO of write-back entries; head is visible on dout while non-empty.
module result_fifo
    import tensor_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);

    wb_entry_t      mem [DEPTH];
    logic [AW:0]    wr_ptr;
    logic [AW:0]    rd_ptr;
    logic           wr_en;
    logic           rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a push into a full FIFO succeeds then.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/tile_result_writer.sv
// Captures 2x2 tile results, computes their byte addresses and drains them to memory
// one write at a time.
module tile_result_writer
    import tensor_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c11ready,
    input  logic        c12ready,
    input  logic        c21ready,
    input  logic        c22ready,
    input  logic [31:0] C11,
    input  logic [31:0] C12,
    input  logic [31:0] C21,
    input  logic [31:0] C22,
    input  logic [31:0] tile_addr,
    input  logic [31:0] row_stride,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic        mem_err,
    output logic        busy,
    output logic [15:0] writes_done,
    output logic        err_overflow,
    output logic        err_collide,
    output logic        err_bus,
    output logic [1:0]  dbg_state
);

    // Write port handshake: mem_req rises with mem_addr/mem_wdata and holds them
    // stable until a cycle where mem_req && mem_gnt; that cycle transfers the write.
    // Exactly one mem_rvalid (with mem_err) follows later; no new request until then.

    wb_state_e   state;
    logic [31:0] tile_base;
    logic [31:0] stride;
    logic [3:0]  stb;
    logic        push_req;
    logic        push_ok;
    logic        collide;
    wb_entry_t   push_entry;
    wb_entry_t   fifo_dout;
    wb_entry_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_pop;
    logic        have_next;

    assign stb       = {c22ready, c21ready, c12ready, c11ready};
    assign push_req  = |stb;
    assign collide   = (stb & (stb - 4'd1)) != 4'd0;
    assign fifo_pop  = (state == WB_REQ) && mem_gnt;
    assign push_ok   = push_req && (!fifo_full || fifo_pop);
    // An empty FIFO forwards the entry being pushed so the request can start a cycle earlier.
    assign head      = fifo_empty ? push_entry : fifo_dout;
    assign have_next = !fifo_empty || push_ok;

    assign mem_we    = 1'b1;
    assign mem_be    = WB_BE;
    assign dbg_state = state;

    always_comb begin
        push_entry = '0;
        if (c11ready) begin
            push_entry.addr = tile_addr;
            push_entry.data = C11;
        end else if (c12ready) begin
            push_entry.addr = elem_addr(tile_base, stride, 1'b0, 1'b1);
            push_entry.data = C12;
        end else if (c21ready) begin
            push_entry.addr = elem_addr(tile_base, stride, 1'b1, 1'b0);
            push_entry.data = C21;
        end else if (c22ready) begin
            push_entry.addr = elem_addr(tile_base, stride, 1'b1, 1'b1);
            push_entry.data = C22;
        end
    end

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= WB_IDLE;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                WB_IDLE: begin
                    busy <= have_next;
                    if (have_next) begin
                        state     <= WB_REQ;
                        mem_req   <= 1'b1;
                        mem_addr  <= head.addr;
                        mem_wdata <= head.data;
                    end
                end
                WB_REQ: begin
                    busy <= 1'b1;
                    if (mem_gnt) begin
                        state   <= WB_WAIT;
                        mem_req <= 1'b0;
                    end
                end
                WB_WAIT: begin
                    if (mem_rvalid) begin
                        busy <= have_next;
                        if (have_next) begin
                            state     <= WB_REQ;
                            mem_req   <= 1'b1;
                            mem_addr  <= head.addr;
                            mem_wdata <= head.data;
                        end else begin
                            state <= WB_IDLE;
                        end
                    end else begin
                        busy <= 1'b1;
                    end
                end
                default: begin
                    state   <= WB_IDLE;
                    mem_req <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tile_base    <= '0;
            stride       <= '0;
            writes_done  <= '0;
            err_overflow <= 1'b0;
            err_collide  <= 1'b0;
            err_bus      <= 1'b0;
        end else begin
            if (c11ready) begin
                tile_base <= tile_addr;
                stride    <= row_stride;
            end
            if (collide) err_collide <= 1'b1;
            if (push_req && !push_ok) err_overflow <= 1'b1;
            if (state == WB_WAIT && mem_rvalid) begin
                writes_done <= writes_done + 16'd1;
                if (mem_err) err_bus <= 1'b1;
            end
        end
    end

endmodule
